// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard for the 2R/1W register file: round-robin
// arbitration of result producers onto the write port plus RAW/WAW issue stall.
module regfile_wb_sched #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned XLEN     = 32,
  localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*SEL_W-1:0] i_req_sel,
  input  logic [NUM_REQ*XLEN-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic                     i_issue_en,
  input  logic [SEL_W-1:0]         i_issue_dst,
  input  logic [SEL_W-1:0]         i_chk_sel_1,
  input  logic [SEL_W-1:0]         i_chk_sel_2,
  output logic                     o_stall,
  output logic                     o_wr_en,
  output logic [SEL_W-1:0]         o_wr_sel,
  output logic [XLEN-1:0]          o_wr_data
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]    last_q;
  logic [PTR_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                hs;
  logic [SEL_W-1:0]    gnt_sel;
  logic [XLEN-1:0]     gnt_data;
  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;
  logic [NUM_REGS-1:0] busy_vec;
  logic                wr_en_q;
  logic [SEL_W-1:0]    wr_sel_q;
  logic [XLEN-1:0]     wr_data_q;
  logic                stall;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    grant   = '0;
    hs      = 1'b0;
    gnt_idx = last_q;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_q) + i) % NUM_REQ;
      if (!hs && i_rst_n && i_req_valid[idx]) begin
        hs         = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PTR_W'(idx);
      end
    end
  end

  assign gnt_sel  = i_req_sel[gnt_idx*SEL_W +: SEL_W];
  assign gnt_data = i_req_data[gnt_idx*XLEN +: XLEN];

  // A write sitting in the output register is still uncommitted, so it counts as busy.
  always_comb begin
    busy_vec = sb_q;
    if (wr_en_q) busy_vec[wr_sel_q] = 1'b1;
    busy_vec[0] = 1'b0;
  end

  assign stall = i_issue_en &&
                 (busy_vec[i_chk_sel_1] || busy_vec[i_chk_sel_2] || busy_vec[i_issue_dst]);

  // Clear first, then set, so an issue to the same register on a handshake edge wins.
  always_comb begin
    sb_d = sb_q;
    if (hs) sb_d[gnt_sel] = 1'b0;
    if (i_issue_en && !stall && (i_issue_dst != '0)) sb_d[i_issue_dst] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q    <= PTR_W'(NUM_REQ - 1);
      sb_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      sb_q    <= sb_d;
      wr_en_q <= hs && (gnt_sel != '0);
      if (hs) begin
        last_q    <= gnt_idx;
        wr_sel_q  <= gnt_sel;
        wr_data_q <= gnt_data;
      end
    end
  end

  assign o_req_ready = grant;
  assign o_stall     = stall;
  assign o_wr_en     = wr_en_q;
  assign o_wr_sel    = wr_sel_q;
  assign o_wr_data   = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_regfile_wb_sched;

  localparam int NR    = 3;
  localparam int NREGS = 32;
  localparam int XL    = 32;
  localparam int SW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*SW-1:0] req_sel;
  logic [NR*XL-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             issue_en;
  logic [SW-1:0]    issue_dst;
  logic [SW-1:0]    chk1;
  logic [SW-1:0]    chk2;
  logic             stall;
  logic             wr_en;
  logic [SW-1:0]    wr_sel;
  logic [XL-1:0]    wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.NUM_REQ(NR), .NUM_REGS(NREGS), .XLEN(XL)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_sel   (req_sel),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_issue_en  (issue_en),
    .i_issue_dst (issue_dst),
    .i_chk_sel_1 (chk1),
    .i_chk_sel_2 (chk2),
    .o_stall     (stall),
    .o_wr_en     (wr_en),
    .o_wr_sel    (wr_sel),
    .o_wr_data   (wr_data)
  );

  function automatic bit model_busy(input logic [NREGS-1:0] sb, input bit wen,
                                    input logic [SW-1:0] wsel, input logic [SW-1:0] r);
    return (r != 0) && (sb[r] || (wen && wsel == r));
  endfunction

  task automatic idle_inputs();
    req_valid = '0;
    req_sel   = '0;
    req_data  = '0;
    issue_en  = 1'b0;
    issue_dst = '0;
    chk1      = '0;
    chk2      = '0;
  endtask

  task automatic set_req(input int k, input logic v, input logic [SW-1:0] s, input logic [XL-1:0] d);
    req_valid[k]        = v;
    req_sel[k*SW +: SW] = s;
    req_data[k*XL +: XL] = d;
  endtask

  task automatic set_issue(input logic en, input logic [SW-1:0] dst,
                           input logic [SW-1:0] s1, input logic [SW-1:0] s2);
    issue_en  = en;
    issue_dst = dst;
    chk1      = s1;
    chk2      = s2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    set_req(0, 1'b1, 5'd5, 32'h11);
    set_req(1, 1'b1, 5'd6, 32'h22);
    set_req(2, 1'b1, 5'd7, 32'h33);
    set_issue(1'b1, 5'd5, 5'd6, 5'd7);
    repeat (2) @(posedge clk);
    #3;
    n_tests++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    n_tests++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    @(negedge clk);
    rst_n = 1'b1;
    issue_en = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 001", req_ready); end
  endtask

  task automatic test_round_robin();
    logic [SW-1:0] sels [NR];
    logic [XL-1:0] dats [NR];
    logic [NR-1:0] exp_r;
    apply_reset();
    sels[0] = 5'd5; sels[1] = 5'd6; sels[2] = 5'd7;
    dats[0] = 32'hA0A0_0005; dats[1] = 32'hB1B1_0006; dats[2] = 32'hC2C2_0007;
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, sels[k], dats[k]);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_r = '0;
      exp_r[i % NR] = 1'b1;
      n_tests++;
      if (req_ready !== exp_r) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_r); end
      tick();
      n_tests++;
      if (wr_en !== 1'b1 || wr_sel !== sels[i % NR] || wr_data !== dats[i % NR]) begin
        n_fail++;
        $display("FAIL rr_write[%0d]: got en=%b sel=%0d data=%h expected en=1 sel=%0d data=%h",
                 i, wr_en, wr_sel, wr_data, sels[i % NR], dats[i % NR]);
      end
    end
    idle_inputs();
    tick();
    n_tests++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle_wr_en: got %b expected 0", wr_en); end
  endtask

  task automatic test_raw();
    apply_reset();
    set_issue(1'b1, 5'd9, 5'd1, 5'd2);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall: got %b expected 0", stall); end
    tick();
    set_issue(1'b1, 5'd0, 5'd9, 5'd0);
    set_req(1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_N: got %b expected 1", stall); end
    n_tests++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL raw_grant: got %b expected 010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_tests++;
    if (wr_en !== 1'b1 || wr_sel !== 5'd9 || wr_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL raw_write: got en=%b sel=%0d data=%h expected en=1 sel=9 data=deadbeef", wr_en, wr_sel, wr_data);
    end
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_N1: got %b expected 1", stall); end
    tick();
    n_tests++;
    if (wr_en !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_release: got en=%b stall=%b expected en=0 stall=0", wr_en, stall);
    end
  endtask

  task automatic test_set_clear();
    apply_reset();
    set_issue(1'b1, 5'd12, 5'd0, 5'd0);
    set_req(0, 1'b1, 5'd12, 32'h5555_AAAA);
    #1;
    n_tests++;
    if (stall !== 1'b0 || req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL sc_same_edge: got stall=%b ready=%b expected stall=0 ready=001", stall, req_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (wr_en !== 1'b1 || wr_sel !== 5'd12) begin
      n_fail++;
      $display("FAIL sc_write: got en=%b sel=%0d expected en=1 sel=12", wr_en, wr_sel);
    end
    tick();
    set_issue(1'b1, 5'd0, 5'd12, 5'd0);
    #1;
    n_tests++;
    if (wr_en !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sc_set_wins: got en=%b stall=%b expected en=0 stall=1", wr_en, stall);
    end
  endtask

  task automatic test_reg0();
    apply_reset();
    set_req(2, 1'b1, 5'd0, 32'h0000_1234);
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    n_tests++;
    if (req_ready !== 3'b100 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_accept: got ready=%b stall=%b expected ready=100 stall=0", req_ready, stall);
    end
    tick();
    req_valid = '0;
    #1;
    n_tests++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL r0_no_write: got %b expected 0", wr_en); end
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_no_stall: got %b expected 0", stall); end
    tick();
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_sb_unchanged: got %b expected 0", stall); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_issue(1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    set_issue(1'b1, 5'd4, 5'd0, 5'd0);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_issue4_stall: got %b expected 0", stall); end
    tick();
    issue_en = 1'b0;
    set_req(0, 1'b1, 5'd20, 32'h0000_ABCD);
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_wr_en: got %b expected 1", wr_en); end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (wr_en !== 1'b0 || wr_sel !== 5'd0 || wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_async_clear: got en=%b sel=%0d data=%h expected en=0 sel=0 data=0", wr_en, wr_sel, wr_data);
    end
    #2;
    rst_n = 1'b1;
    tick();
    set_issue(1'b1, 5'd0, 5'd3, 5'd4);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_sb_cleared: got %b expected 0", stall); end
  endtask

  task automatic test_random();
    int               m_ptr;
    logic [NREGS-1:0] m_sb;
    bit               m_wen;
    logic [SW-1:0]    m_wsel;
    logic [XL-1:0]    m_wdata;
    apply_reset();
    m_ptr = NR - 1;
    m_sb = '0;
    m_wen = 1'b0;
    m_wsel = '0;
    m_wdata = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int            g;
      int            c;
      bit            v [NR];
      logic [SW-1:0] s [NR];
      logic [XL-1:0] d [NR];
      logic [NR-1:0] exp_ready;
      bit            exp_stall;
      n_tests++;
      if (wr_en !== m_wen || wr_sel !== m_wsel || wr_data !== m_wdata) begin
        n_fail++;
        $display("FAIL rnd_write[%0d]: got en=%b sel=%0d data=%h expected en=%b sel=%0d data=%h",
                 cyc, wr_en, wr_sel, wr_data, m_wen, m_wsel, m_wdata);
      end
      for (int k = 0; k < NR; k++) begin
        v[k] = ($urandom_range(0, 2) != 0);
        s[k] = SW'($urandom_range(0, 7));
        d[k] = $urandom;
        set_req(k, v[k], s[k], d[k]);
      end
      set_issue(($urandom_range(0, 1) != 0), SW'($urandom_range(0, 7)),
                SW'($urandom_range(0, 7)), SW'($urandom_range(0, 7)));
      #1;
      g = -1;
      for (int j = 1; j <= NR; j++) begin
        c = (m_ptr + j) % NR;
        if (g < 0 && v[c]) g = c;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_stall = issue_en && (model_busy(m_sb, m_wen, m_wsel, chk1) ||
                               model_busy(m_sb, m_wen, m_wsel, chk2) ||
                               model_busy(m_sb, m_wen, m_wsel, issue_dst));
      n_tests++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, req_ready, exp_ready);
      end
      n_tests++;
      if (stall !== exp_stall) begin
        n_fail++;
        $display("FAIL rnd_stall[%0d]: got %b expected %b", cyc, stall, exp_stall);
      end
      if (g >= 0) begin
        m_ptr   = g;
        m_wen   = (s[g] != 0);
        m_wsel  = s[g];
        m_wdata = d[g];
        m_sb[s[g]] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (issue_en && !exp_stall && issue_dst != 0) m_sb[issue_dst] = 1'b1;
      m_sb[0] = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_raw();
    test_set_clear();
    test_reg0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
